// File: rtl/romreset_sequencer.sv
// rtl/romreset_sequencer.sv - boot sequencer issuing reset ROM words to decode before main fetch
module romreset_sequencer #(
    parameter int RST_LEN = 3,
    parameter int ADDR_W  = 3,
    parameter int INST_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_dout,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              busy,
    output logic              done,
    output logic              main_en
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_VALID  = 2'd1,
        S_FINISH = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RST_LEN - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [INST_W-1:0]   inst_nxt;
    logic                valid_nxt;
    logic                handshake;

    assign handshake = inst_valid & inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            rom_addr   <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            rom_addr   <= addr_nxt;
            inst       <= inst_nxt;
            inst_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        inst_nxt  = inst;
        valid_nxt = inst_valid;
        case (state)
            S_LOAD: begin
                inst_nxt  = rom_dout;
                valid_nxt = 1'b1;
                state_nxt = S_VALID;
            end
            S_VALID: begin
                if (handshake) begin
                    valid_nxt = 1'b0;
                    // Last word wraps the address home so RUN always presents address 0
                    if (rom_addr == LAST_ADDR) begin
                        addr_nxt  = '0;
                        state_nxt = S_FINISH;
                    end else begin
                        addr_nxt  = rom_addr + ADDR_W'(1);
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_FINISH: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                addr_nxt  = '0;
                valid_nxt = 1'b0;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
                addr_nxt  = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign done    = (state == S_FINISH);
    assign main_en = (state == S_RUN);
    assign busy    = (state != S_RUN);

endmodule

// File: tb/tb_romreset_sequencer.sv
// tb/tb_romreset_sequencer.sv - self-checking bench for romreset_sequencer
module tb_romreset_sequencer;

    localparam int AW  = 3;
    localparam int IW  = 19;
    localparam int LEN = 3;

    logic          clk = 1'b0;
    logic          rst, start, inst_ready;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_dout, inst;
    logic          inst_valid, busy, done, main_en;

    logic          rst1, start1, ready1;
    logic [AW-1:0] rom_addr1;
    logic [IW-1:0] rom_dout1, inst1;
    logic          valid1, busy1, done1, main_en1;

    logic [IW-1:0] rom [8];

    always #5 clk = ~clk;

    assign rom_dout  = rom[rom_addr];
    assign rom_dout1 = rom[rom_addr1];

    romreset_sequencer #(.RST_LEN(LEN), .ADDR_W(AW), .INST_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .busy(busy), .done(done), .main_en(main_en)
    );

    romreset_sequencer #(.RST_LEN(1), .ADDR_W(AW), .INST_W(IW)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
        .inst(inst1), .inst_valid(valid1), .inst_ready(ready1),
        .busy(busy1), .done(done1), .main_en(main_en1)
    );

    typedef struct {
        logic          rst;
        logic          start;
        logic          ready;
        logic          valid;
        logic [IW-1:0] inst;
        logic [AW-1:0] addr;
        logic          done;
        logic          men;
        logic          busy;
    } vec_t;

    vec_t tbl [17];
    int   vecs = 0;
    int   miscompares = 0;

    // behavioural model: mode 0 = issuing words, 1 = finishing, 2 = running main program
    int            m_mode;
    int            m_word;
    bit            m_shown;
    logic [IW-1:0] m_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [IW-1:0] i,
                            input logic [AW-1:0] a, input logic d, input logic m, input logic b);
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(v));
        chk({tag, ".inst"},       32'(inst),       32'(i));
        chk({tag, ".rom_addr"},   32'(rom_addr),   32'(a));
        chk({tag, ".done"},       32'(done),       32'(d));
        chk({tag, ".main_en"},    32'(main_en),    32'(m));
        chk({tag, ".busy"},       32'(busy),       32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_row(input int r, input string tag);
        rst        = tbl[r].rst;
        start      = tbl[r].start;
        inst_ready = tbl[r].ready;
        step();
        chk_outs($sformatf("%s[%0d]", tag, r), tbl[r].valid, tbl[r].inst, tbl[r].addr,
                 tbl[r].done, tbl[r].men, tbl[r].busy);
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rdy);
        if (r) begin
            m_mode = 0; m_word = 0; m_shown = 0; m_inst = '0;
        end else if (m_mode == 0) begin
            if (!m_shown) begin
                m_shown = 1;
                m_inst  = rom[m_word];
            end else if (rdy) begin
                m_shown = 0;
                if (m_word == LEN - 1) begin
                    m_word = 0;
                    m_mode = 1;
                end else begin
                    m_word = m_word + 1;
                end
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (s) begin
            m_mode = 0; m_word = 0; m_shown = 0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inst_ready = 1'b0;
        rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b0;
        for (int k = 0; k < 8; k++) rom[k] = IW'($urandom);
        rom[0] = 19'h7f000; rom[1] = 19'h74000; rom[2] = 19'h7f000;

        //            rst start rdy  valid inst        addr done men busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 19'h00000, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 19'h7f000, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h7f000, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 19'h74000, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h74000, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 19'h7f000, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h7f000, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h7f000, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h7f000, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h7f000, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h7f000, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h74000, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h74000, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h7f000, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h7f000, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h7f000, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h7f000, 3'd0, 1'b0, 1'b1, 1'b0};

        step();
        for (int r = 0; r < 17; r++) apply_row(r, "tbl");

        // backpressure on word 1
        rst = 1'b1; start = 1'b0; inst_ready = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        inst_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) chk_outs($sformatf("stall%0d", k), 1'b1, 19'h74000, 3'd1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_outs($sformatf("stall%0d", k), 1'b1, 19'h74000, 3'd1, 1'b0, 1'b0, 1'b1);
        end
        inst_ready = 1'b1;
        step();
        chk_outs("resume", 1'b0, 19'h74000, 3'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk_outs("word2", 1'b1, 19'h7f000, 3'd2, 1'b0, 1'b0, 1'b1);

        // asynchronous abort while word 2 is offered
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 19'h00000, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        for (int r = 1; r < 8; r++) apply_row(r, "replay");

        // single-word configuration
        ready1 = 1'b1;
        chk("len1.reset.valid", 32'(valid1), 32'd0);
        chk("len1.reset.busy", 32'(busy1), 32'd1);
        rst1 = 1'b0;
        step();
        chk("len1.e1.valid", 32'(valid1), 32'd1);
        chk("len1.e1.inst", 32'(inst1), 32'h7f000);
        chk("len1.e1.addr", 32'(rom_addr1), 32'd0);
        step();
        chk("len1.e2.valid", 32'(valid1), 32'd0);
        chk("len1.e2.done", 32'(done1), 32'd1);
        chk("len1.e2.main_en", 32'(main_en1), 32'd0);
        chk("len1.e2.addr", 32'(rom_addr1), 32'd0);
        step();
        chk("len1.e3.done", 32'(done1), 32'd0);
        chk("len1.e3.main_en", 32'(main_en1), 32'd1);
        chk("len1.e3.busy", 32'(busy1), 32'd0);

        // randomized run against the model
        for (int c = 0; c < 800; c++) begin
            rst        = (c == 0) || ($urandom_range(0, 149) == 0);
            start      = ($urandom_range(0, 5) == 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            rom[$urandom_range(0, 7)] = IW'($urandom);
            @(posedge clk);
            model_edge(rst, start, inst_ready);
            @(negedge clk);
            chk_outs($sformatf("rand%0d", c), logic'(m_mode == 0 && m_shown), m_inst, AW'(m_word),
                     logic'(m_mode == 1), logic'(m_mode == 2), logic'(m_mode != 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
